// File: rtl/trit_spi_arbiter.sv
// Two-requester round-robin arbiter and sequencer for a trit-serial SPI link.
// Latency: request sampled in IDLE -> done pulse 2+2*TRITS*CLK_DIV cycles later.
// Backpressure: requests are level-held and wait while busy; sampled only in IDLE.
module trit_spi_arbiter #(
    parameter int TRITS   = 3,
    parameter int CLK_DIV = 2
) (
    input  logic                 I_clk,
    input  logic                 I_rst,
    input  logic                 I_req_a,
    input  logic [2*TRITS-1:0]   I_data_a,
    output logic                 O_done_a,
    input  logic                 I_req_b,
    input  logic [2*TRITS-1:0]   I_data_b,
    output logic                 O_done_b,
    output logic [2*TRITS-1:0]   O_rdata,
    output logic                 O_err,
    output logic                 O_busy,
    output logic                 O_cs,
    output logic [1:0]           O_mosi,
    input  logic [1:0]           I_miso,
    output logic [1:0]           O_sck
);

    localparam int W  = 2 * TRITS;
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int TW = (TRITS > 1) ? $clog2(TRITS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETUP,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] div_cnt;
    logic [TW-1:0] trit_cnt;
    logic [W-1:0]  tx_sr, rx_sr, tx_shift, rx_shift, data_sel;
    logic          gnt_b, last_b, pick_b, div_last, trit_last, tx_bad, err;

    always_comb begin
        pick_b   = (I_req_a && I_req_b) ? !last_b : I_req_b;
        data_sel = pick_b ? I_data_b : I_data_a;
        tx_bad   = 1'b0;
        for (int i = 0; i < TRITS; i++) begin
            if (data_sel[2*i +: 2] == 2'b11) tx_bad = 1'b1;
        end
        div_last  = (div_cnt == DW'(CLK_DIV - 1));
        trit_last = (trit_cnt == TW'(TRITS - 1));
        tx_shift  = tx_sr << 2;
        rx_shift  = rx_sr << 2;
        rx_shift[1:0] = I_miso;
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (I_req_a || I_req_b) state_nxt = S_LOAD;
            S_LOAD:   state_nxt = S_SETUP;
            S_SETUP:  if (div_last) state_nxt = S_SAMPLE;
            S_SAMPLE: if (div_last) state_nxt = trit_last ? S_DONE : S_SETUP;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // The word is captured on the IDLE->LOAD edge so its MSB trit is on the line during LOAD.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            div_cnt  <= '0;
            trit_cnt <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            err      <= 1'b0;
            gnt_b    <= 1'b0;
            last_b   <= 1'b1;
        end else begin
            if ((state == S_SETUP || state == S_SAMPLE) && !div_last)
                div_cnt <= div_cnt + 1'b1;
            else
                div_cnt <= '0;
            case (state)
                S_IDLE: begin
                    if (I_req_a || I_req_b) begin
                        gnt_b    <= pick_b;
                        tx_sr    <= data_sel;
                        err      <= tx_bad;
                        trit_cnt <= '0;
                    end
                end
                S_SAMPLE: begin
                    if (div_last) begin
                        tx_sr    <= tx_shift;
                        rx_sr    <= rx_shift;
                        trit_cnt <= trit_cnt + 1'b1;
                        if (I_miso == 2'b11) err <= 1'b1;
                    end
                end
                S_DONE:  last_b <= gnt_b;
                default: ;
            endcase
        end
    end

    always_comb begin
        O_busy   = (state != S_IDLE);
        O_cs     = (state == S_LOAD) || (state == S_SETUP) || (state == S_SAMPLE);
        O_sck    = (state == S_SETUP) ? 2'b10 : (state == S_SAMPLE) ? 2'b01 : 2'b00;
        O_mosi   = O_cs ? tx_sr[W-1 -: 2] : 2'b00;
        O_done_a = (state == S_DONE) && !gnt_b;
        O_done_b = (state == S_DONE) && gnt_b;
        O_rdata  = rx_sr;
        O_err    = err;
    end

endmodule
